// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and constants for the F1 start-gantry sequencer
// Contents:
//   f1_state_t  sequencer states (REACT only reachable with F1_REACTION_TIMER_EN)
//   LFSR_SEED   reset value of the hold-delay LFSR (must be non-zero)
package f1_pkg;

  typedef enum logic [2:0] {IDLE, COUNT, HOLD, REACT} f1_state_t;

  localparam int LFSR_SEED = 1;

endpackage

// File: rtl/f1_start_ctrl_if.sv
// rtl/f1_start_ctrl_if.sv - control/lamp bundle between gantry sequencer and top-level logic
// Signals:
//   trigger, abort           start request / cancel            (master -> slave)
//   data_out[N_LIGHTS]       lamp pattern                      (slave -> master)
//   lights_out               1-cycle pulse when lamps go dark  (slave -> master)
//   busy                     sequencer not idle                (slave -> master)
//   F1_REACTION_TIMER_EN adds btn (master -> slave) and react_time[16],
//   react_valid, false_start (slave -> master).
interface f1_start_ctrl_if #(
  parameter int N_LIGHTS = 8
);

  logic                trigger;
  logic                abort;
  logic [N_LIGHTS-1:0] data_out;
  logic                lights_out;
  logic                busy;
`ifdef F1_REACTION_TIMER_EN
  logic                btn;
  logic [15:0]         react_time;
  logic                react_valid;
  logic                false_start;

  modport master (
    output trigger, abort, btn,
    input  data_out, lights_out, busy, react_time, react_valid, false_start
  );

  modport slave (
    input  trigger, abort, btn,
    output data_out, lights_out, busy, react_time, react_valid, false_start
  );
`else
  modport master (
    output trigger, abort,
    input  data_out, lights_out, busy
  );

  modport slave (
    input  trigger, abort,
    output data_out, lights_out, busy
  );
`endif

endinterface

// File: rtl/f1_delay_lfsr.sv
// rtl/f1_delay_lfsr.sv - free-running Fibonacci LFSR supplying the random hold delay
// Ports:
//   clk  in          clock
//   rst  in          synchronous active-high reset, loads LFSR_SEED
//   rnd  out [RND_W] current LFSR state, never zero
module f1_delay_lfsr
  import f1_pkg::*;
#(
  parameter int RND_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  output logic [RND_W-1:0] rnd
);

  // Taps on the two top bits; a non-zero seed keeps the state out of the
  // all-zero lock-up value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd <= RND_W'(LFSR_SEED);
    end else begin
      rnd <= {rnd[RND_W-2:0], rnd[RND_W-1] ^ rnd[RND_W-2]};
    end
  end

endmodule

// File: rtl/f1_start_ctrl.sv
// rtl/f1_start_ctrl.sv - abortable race-start sequencer for the F1 lamp gantry
// Lights one lamp per tick, holds all lamps for a random 1..2^RND_W-1 ticks,
// then extinguishes them with a one-cycle lights_out pulse.
// Optional feature macro: F1_REACTION_TIMER_EN (REACT state, btn input,
// reaction-time / false-start reporting).
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of f1_start_ctrl_if (trigger, abort, data_out,
//        lights_out, busy, plus reaction-timer signals when enabled)
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int N_LIGHTS = 8,
  parameter int RND_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  f1_start_ctrl_if.slave   bus
);

  localparam int TC_W = $clog2(TICK_DIV);

  f1_state_t           state_q, state_n;
  logic [TC_W-1:0]     tc_q, tc_n;
  logic [N_LIGHTS-1:0] lamps_q, lamps_n;
  logic [RND_W-1:0]    dly_q, dly_n;
  logic                lights_q, lights_n;
  logic                busy_q;
  logic [RND_W-1:0]    rnd;
  logic                tick;
`ifdef F1_REACTION_TIMER_EN
  logic [15:0]         rc_q, rc_n;
  logic [15:0]         rtime_q, rtime_n;
  logic                rvalid_q, rvalid_n;
  logic                fstart_q, fstart_n;
`endif

  f1_delay_lfsr #(.RND_W(RND_W)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  assign tick = (tc_q == TC_W'(TICK_DIV - 1));

  always_comb begin
    state_n  = state_q;
    tc_n     = tc_q;
    lamps_n  = lamps_q;
    dly_n    = dly_q;
    lights_n = 1'b0;
`ifdef F1_REACTION_TIMER_EN
    rc_n     = rc_q;
    rtime_n  = rtime_q;
    rvalid_n = 1'b0;
    fstart_n = 1'b0;
`endif
    if (bus.abort) begin
      state_n = IDLE;
      tc_n    = '0;
      lamps_n = '0;
    end
`ifdef F1_REACTION_TIMER_EN
    else if (bus.btn && (state_q == COUNT || state_q == HOLD)) begin
      fstart_n = 1'b1;
      state_n  = IDLE;
      tc_n     = '0;
      lamps_n  = '0;
    end
`endif
    else begin
      case (state_q)
        IDLE: begin
          lamps_n = '0;
          if (bus.trigger) begin
            state_n = COUNT;
            tc_n    = '0;
          end
        end
        COUNT: begin
          tc_n = tick ? '0 : tc_q + TC_W'(1);
          if (tick) begin
            lamps_n = {lamps_q[N_LIGHTS-2:0], 1'b1};
            // Lower lamps all lit means this shift completes the gantry.
            if (&lamps_q[N_LIGHTS-2:0]) begin
              state_n = HOLD;
              dly_n   = rnd;
              tc_n    = '0;
            end
          end
        end
        HOLD: begin
          tc_n = tick ? '0 : tc_q + TC_W'(1);
          if (tick) begin
            if (dly_q == RND_W'(1)) begin
              lamps_n  = '0;
              lights_n = 1'b1;
              tc_n     = '0;
`ifdef F1_REACTION_TIMER_EN
              state_n  = REACT;
              rc_n     = '0;
`else
              state_n  = IDLE;
`endif
            end else begin
              dly_n = dly_q - RND_W'(1);
            end
          end
        end
`ifdef F1_REACTION_TIMER_EN
        REACT: begin
          rc_n = (rc_q == 16'hFFFF) ? rc_q : rc_q + 16'd1;
          if (bus.btn) begin
            rtime_n  = rc_q;
            rvalid_n = 1'b1;
            state_n  = IDLE;
          end
        end
`endif
        default: begin
          state_n = IDLE;
          lamps_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tc_q     <= '0;
      lamps_q  <= '0;
      dly_q    <= '0;
      lights_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef F1_REACTION_TIMER_EN
      rc_q     <= '0;
      rtime_q  <= '0;
      rvalid_q <= 1'b0;
      fstart_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      tc_q     <= tc_n;
      lamps_q  <= lamps_n;
      dly_q    <= dly_n;
      lights_q <= lights_n;
      busy_q   <= (state_n != IDLE);
`ifdef F1_REACTION_TIMER_EN
      rc_q     <= rc_n;
      rtime_q  <= rtime_n;
      rvalid_q <= rvalid_n;
      fstart_q <= fstart_n;
`endif
    end
  end

  assign bus.data_out   = lamps_q;
  assign bus.lights_out = lights_q;
  assign bus.busy       = busy_q;
`ifdef F1_REACTION_TIMER_EN
  assign bus.react_time  = rtime_q;
  assign bus.react_valid = rvalid_q;
  assign bus.false_start = fstart_q;
`endif

endmodule

// File: tb/tb_f1_start_ctrl.sv
// tb/tb_f1_start_ctrl.sv - directed self-checking bench for f1_start_ctrl
// Exercises the full start sequence, random hold timing against an LFSR
// reference, abort, mid-sequence reset and ignored triggers; with
// F1_REACTION_TIMER_EN also reaction time and false start.
module tb_f1_start_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] m_lfsr = 7'd1;
  logic [6:0] m_seen = 7'd1;

  always #5 clk = ~clk;

  f1_start_ctrl_if #(.N_LIGHTS(8)) bus ();

  f1_start_ctrl #(.TICK_DIV(4), .N_LIGHTS(8), .RND_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [6:0] lfsr_step(input logic [6:0] l);
    return {l[5:0], l[6] ^ l[5]};
  endfunction

  // m_seen is the LFSR value the design samples at the most recent edge.
  always @(posedge clk) begin
    m_seen <= m_lfsr;
    m_lfsr <= rst ? 7'd1 : lfsr_step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle trigger; returns at the negedge right after the sampling edge.
  task automatic start();
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_data", 32'(bus.data_out), 32'h00);
  endtask

  task automatic lamps(input bit poke);
    logic [7:0] prev, nxt;
    for (int k = 1; k <= 8; k++) begin
      prev = 8'((1 << (k - 1)) - 1);
      nxt  = 8'((1 << k) - 1);
      cyc(1);
      bus.trigger = poke;
      cyc(1);
      bus.trigger = 1'b0;
      cyc(1);
      chk($sformatf("lamp%0d_before", k), 32'(bus.data_out), 32'(prev));
      cyc(1);
      chk($sformatf("lamp%0d", k), 32'(bus.data_out), 32'(nxt));
      chk($sformatf("lamp%0d_busy", k), 32'(bus.busy), 32'd1);
    end
  endtask

  task automatic hold(input bit poke);
    int d;
    d = int'(m_seen);
    for (int i = 1; i <= 4 * d; i++) begin
      cyc(1);
      bus.trigger = poke && (i % 4 == 1) && (i < 4 * d);
      if (i == 4 * d - 1) begin
        chk("hold_lights_early", 32'(bus.lights_out), 32'd0);
        chk("hold_data_ff", 32'(bus.data_out), 32'hFF);
      end
      if (i == 4 * d) begin
        chk("lights_pulse", 32'(bus.lights_out), 32'd1);
        chk("lights_data", 32'(bus.data_out), 32'h00);
`ifdef F1_REACTION_TIMER_EN
        chk("lights_busy", 32'(bus.busy), 32'd1);
`else
        chk("lights_busy", 32'(bus.busy), 32'd0);
`endif
      end
    end
    bus.trigger = 1'b0;
    cyc(1);
    chk("lights_one_cycle", 32'(bus.lights_out), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.trigger = 1'b0;
    bus.abort   = 1'b0;
`ifdef F1_REACTION_TIMER_EN
    bus.btn     = 1'b0;
`endif
    cyc(3);
    chk("rst_data", 32'(bus.data_out), 32'h00);
    chk("rst_lights", 32'(bus.lights_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Full sequence with random hold.
    start();
    lamps(1'b0);
    hold(1'b0);
`ifdef F1_REACTION_TIMER_EN
    cyc(36);
    bus.btn = 1'b1;
    cyc(1);
    bus.btn = 1'b0;
    chk("react_valid", 32'(bus.react_valid), 32'd1);
    chk("react_time", 32'(bus.react_time), 32'd37);
    chk("react_busy", 32'(bus.busy), 32'd0);
    cyc(1);
    chk("react_valid_pulse", 32'(bus.react_valid), 32'd0);
    chk("react_time_held", 32'(bus.react_time), 32'd37);
`endif

    // Abort at 0x07.
    start();
    cyc(12);
    chk("abort_pre_data", 32'(bus.data_out), 32'h07);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    chk("abort_data", 32'(bus.data_out), 32'h00);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_lights", 32'(bus.lights_out), 32'd0);
    cyc(3);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    chk("abort_idle_lights", 32'(bus.lights_out), 32'd0);

    // Restart after abort, with triggers pulsed throughout COUNT and HOLD.
    start();
    lamps(1'b1);
    hold(1'b1);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    chk("post_run2_busy", 32'(bus.busy), 32'd0);

    // Reset in HOLD with trigger held.
    start();
    cyc(32);
    chk("rst_hold_pre", 32'(bus.data_out), 32'hFF);
    rst         = 1'b1;
    bus.trigger = 1'b1;
    cyc(1);
    chk("rst_hold_data", 32'(bus.data_out), 32'h00);
    chk("rst_hold_lights", 32'(bus.lights_out), 32'd0);
    chk("rst_hold_busy", 32'(bus.busy), 32'd0);
    cyc(3);
    chk("rst_held_busy", 32'(bus.busy), 32'd0);
    chk("rst_held_data", 32'(bus.data_out), 32'h00);
    rst = 1'b0;
    cyc(1);
    chk("rst_release_busy", 32'(bus.busy), 32'd1);
    bus.trigger = 1'b0;
    bus.abort   = 1'b1;
    cyc(1);
    bus.abort   = 1'b0;
    chk("rst_release_abort", 32'(bus.busy), 32'd0);

`ifdef F1_REACTION_TIMER_EN
    // False start in COUNT.
    start();
    cyc(8);
    chk("fs_pre_data", 32'(bus.data_out), 32'h03);
    bus.btn = 1'b1;
    cyc(1);
    bus.btn = 1'b0;
    chk("false_start", 32'(bus.false_start), 32'd1);
    chk("fs_data", 32'(bus.data_out), 32'h00);
    chk("fs_busy", 32'(bus.busy), 32'd0);
    cyc(1);
    chk("false_start_pulse", 32'(bus.false_start), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
